// File: rtl/puf_uart_host_pkg.sv
`default_nettype none
// ============================================================================
// puf_uart_host_pkg
// Shared FSM state encoding and frame-size constants for the PUF UART host.
// Revision: 1.0
// ============================================================================
package puf_uart_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TX_BYTE   = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_DONE      = 3'd3,
        ST_ABORT     = 3'd4
    } state_t;

    localparam int RESP_BYTES = 16;
    localparam int CHAL_BYTES = 2;
    localparam int DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// uart_byte_rx
// 8N1 receive bit engine with 2-FF synchronizer and mid-bit sampling.
// Revision: 1.0
// ============================================================================
module uart_byte_rx
    import puf_uart_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       en,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       stop_err
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_half  = CLKS_PER_BIT / 2;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic                 r_active;
    logic                 r_start_phase;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_rx_s;
    logic                 w_fall;

    assign w_rx_s = r_sync[1];
    assign w_fall = r_prev & ~w_rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync        <= 2'b11;
            r_prev        <= 1'b1;
            r_active      <= 1'b0;
            r_start_phase <= 1'b0;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            data          <= '0;
            byte_valid    <= 1'b0;
            stop_err      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], rx};
            r_prev     <= r_sync[1];
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            if (!en) begin
                // Disabling the engine drops any frame in progress.
                r_active <= 1'b0;
            end else if (!r_active) begin
                if (w_fall) begin
                    r_active      <= 1'b1;
                    r_start_phase <= 1'b1;
                    r_cnt         <= '0;
                end
            end else if (r_start_phase) begin
                if (r_cnt == c_cnt_w'(c_half - 1)) begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_active <= 1'b0;
                    end else begin
                        r_start_phase <= 1'b0;
                        r_bit_idx     <= '0;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_cnt == c_cnt_w'(CLKS_PER_BIT - 1)) begin
                r_cnt <= '0;
                if (r_bit_idx == 4'(DATA_BITS)) begin
                    r_active <= 1'b0;
                    if (w_rx_s) begin
                        data       <= r_shift;
                        byte_valid <= 1'b1;
                    end else begin
                        stop_err <= 1'b1;
                    end
                end else begin
                    r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_uart_host.sv
`default_nettype none
// ============================================================================
// puf_uart_host
// Sends a 16-bit challenge over UART and assembles a 16-byte PUF response.
// Revision: 1.0
// ============================================================================
module puf_uart_host
    import puf_uart_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CYC  = 2_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [15:0]  challenge,
    output logic         tx_out,
    input  logic         rx,
    output logic         busy,
    output logic [127:0] response,
    output logic         resp_valid,
    output logic         timeout_err,
    output logic         frame_err
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC + 1);

    state_t             r_state;
    logic [15:0]        r_chal;
    logic [3:0]         r_byte_idx;
    logic [3:0]         r_tx_bit;
    logic [c_cnt_w-1:0] r_tx_cnt;
    logic [c_tmo_w-1:0] r_tmo;
    logic               w_rx_en;
    logic [7:0]         w_rx_data;
    logic               w_rx_valid;
    logic               w_rx_stop_err;
    logic               w_tx_next;

    assign w_rx_en = (r_state == ST_WAIT_RESP);
    // r_tx_bit 0 is the start bit, 1..8 data, 9 stop; this is the value of the bit that follows.
    assign w_tx_next = (r_tx_bit < 4'(DATA_BITS)) ? r_chal[r_tx_bit[2:0]] : 1'b1;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .en         (w_rx_en),
        .data       (w_rx_data),
        .byte_valid (w_rx_valid),
        .stop_err   (w_rx_stop_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            tx_out      <= 1'b1;
            busy        <= 1'b0;
            resp_valid  <= 1'b0;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
            response    <= '0;
            r_chal      <= '0;
            r_byte_idx  <= '0;
            r_tx_bit    <= '0;
            r_tx_cnt    <= '0;
            r_tmo       <= '0;
        end else begin
            resp_valid  <= 1'b0;
            timeout_err <= 1'b0;
            frame_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    tx_out <= 1'b1;
                    if (start) begin
                        r_chal     <= challenge;
                        r_byte_idx <= '0;
                        r_tx_bit   <= '0;
                        r_tx_cnt   <= '0;
                        tx_out     <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ST_TX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    if (r_tx_cnt == c_cnt_w'(CLKS_PER_BIT - 1)) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 4'(DATA_BITS + 1)) begin
                            r_tx_bit <= '0;
                            if (r_byte_idx == 4'(CHAL_BYTES - 1)) begin
                                tx_out     <= 1'b1;
                                r_tmo      <= '0;
                                r_byte_idx <= '0;
                                r_state    <= ST_WAIT_RESP;
                            end else begin
                                r_byte_idx <= r_byte_idx + 1'b1;
                                r_chal     <= r_chal >> DATA_BITS;
                                tx_out     <= 1'b0;
                            end
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                            tx_out   <= w_tx_next;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                ST_WAIT_RESP: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (r_tmo == c_tmo_w'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        r_state     <= ST_ABORT;
                    end else if (w_rx_stop_err) begin
                        frame_err <= 1'b1;
                        r_state   <= ST_ABORT;
                    end else if (w_rx_valid) begin
                        response[{r_byte_idx, 3'b000} +: 8] <= w_rx_data;
                        r_byte_idx <= r_byte_idx + 1'b1;
                        if (r_byte_idx == 4'(RESP_BYTES - 1)) begin
                            resp_valid <= 1'b1;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE, ST_ABORT: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    tx_out  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_uart_host.sv
`default_nettype none
// ============================================================================
// tb_puf_uart_host
// Directed/randomized bench with a UART device model and response scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_puf_uart_host;

    localparam int CPB   = 4;
    localparam int TMO   = 2000;
    localparam int FRAME = 10 * CPB;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         start     = 1'b0;
    logic         rx        = 1'b1;
    logic [15:0]  challenge = '0;
    logic         tx_out;
    logic         busy;
    logic         resp_valid;
    logic         timeout_err;
    logic         frame_err;
    logic [127:0] response;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rv   = 0;
    int n_te   = 0;
    int n_fe   = 0;

    logic [127:0] resp_model = '0;
    logic [7:0]   rb [16];

    puf_uart_host #(
        .CLKS_PER_BIT (CPB),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .challenge   (challenge),
        .tx_out      (tx_out),
        .rx          (rx),
        .busy        (busy),
        .response    (response),
        .resp_valid  (resp_valid),
        .timeout_err (timeout_err),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_valid === 1'b1)  n_rv++;
        if (timeout_err === 1'b1) n_te++;
        if (frame_err === 1'b1)   n_fe++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Device model: one 8N1 frame, LSB first, each bit CPB cycles.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        for (int j = 0; j < 10; j++) begin
            rx = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Issues a challenge and checks every cycle of both tx frames against the frame rule.
    task automatic tx_run(input logic [15:0] chal, input bit inject);
        logic [79:0] obs;
        logic [79:0] exp;
        bit          busy_all;
        busy_all = 1'b1;
        @(negedge clk);
        start     = 1'b1;
        challenge = chal;
        @(negedge clk);
        start     = 1'b0;
        challenge = 16'($urandom);
        for (int i = 1; i <= 2 * FRAME; i++) begin
            if (i > 1) @(negedge clk);
            if (inject && i == 10) begin
                start     = 1'b1;
                challenge = ~chal;
            end
            if (inject && i == 11) start = 1'b0;
            obs[i-1] = tx_out;
            busy_all = busy_all & (busy === 1'b1);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            int fr;
            int bt;
            int by;
            fr = i / FRAME;
            bt = (i % FRAME) / CPB;
            by = (int'(chal) >> (8 * fr)) & 255;
            exp[i] = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : 1'((by >> (bt - 1)) & 1);
        end
        chk("tx_frames", 128'(obs), 128'(exp));
        chk("tx_busy_high", 128'(busy_all), 128'd1);
    endtask

    task automatic resp_run(input string tag);
        int rv0;
        rv0 = n_rv;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            send_byte(rb[k], 1'b1);
            resp_model[8*k +: 8] = rb[k];
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk({tag, "_valid_pulses"}, 128'(n_rv - rv0), 128'd1);
        chk({tag, "_response"}, response, resp_model);
        chk({tag, "_busy_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int rv0;
        int te0;
        int fe0;
        int idx;
        bit found;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", 128'(tx_out), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_timeout_err", 128'(timeout_err), 128'd0);
        chk("rst_frame_err", 128'(frame_err), 128'd0);
        chk("rst_response", response, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // rx traffic while idle must not touch the response
        fe0 = n_fe;
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom), 1'b0);
        repeat (6) @(negedge clk);
        chk("idle_rx_response", response, 128'd0);
        chk("idle_rx_frame_err", 128'(n_fe - fe0), 128'd0);
        chk("idle_rx_busy", 128'(busy), 128'd0);

        // Fixed challenge and response pattern, with a start pulse during busy
        tx_run(16'hA55A, 1'b1);
        for (int k = 0; k < 16; k++) begin
            logic [63:0] pat;
            pat   = 64'hABCDEF9876543210;
            rb[k] = pat[8*(k%8) +: 8];
        end
        resp_run("fixed");
        chk("fixed_response_const", response, 128'hABCDEF9876543210ABCDEF9876543210);

        // Randomized challenges and responses
        for (int r = 0; r < 2; r++) begin
            tx_run(16'($urandom), r[0]);
            for (int k = 0; k < 16; k++) rb[k] = 8'($urandom);
            resp_run("rand");
        end

        // No response: timeout TMO cycles after the stop bit
        rv0 = n_rv;
        te0 = n_te;
        tx_run(16'($urandom), 1'b0);
        idx   = 2 * FRAME;
        found = 1'b0;
        while (!found && idx < 2 * FRAME + TMO + 100) begin
            @(negedge clk);
            idx++;
            if (timeout_err === 1'b1) found = 1'b1;
        end
        chk("timeout_cycle", 128'(idx), 128'(2 * FRAME + TMO + 1));
        @(negedge clk);
        chk("timeout_busy_low", 128'(busy), 128'd0);
        repeat (2) @(negedge clk);
        chk("timeout_pulses", 128'(n_te - te0), 128'd1);
        chk("timeout_no_valid", 128'(n_rv - rv0), 128'd0);

        // Byte 5 with a low stop bit
        rv0 = n_rv;
        fe0 = n_fe;
        tx_run(16'($urandom), 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_byte(b, 1'b1);
            resp_model[8*k +: 8] = b;
        end
        send_byte(8'($urandom), 1'b0);
        repeat (8) @(negedge clk);
        chk("ferr_pulses", 128'(n_fe - fe0), 128'd1);
        chk("ferr_bytes_kept", 128'(response[39:0]), 128'(resp_model[39:0]));
        chk("ferr_busy_low", 128'(busy), 128'd0);
        chk("ferr_no_valid", 128'(n_rv - rv0), 128'd0);

        // A 2-cycle glitch before the response must not be counted as a byte
        tx_run(16'($urandom), 1'b0);
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 16; k++) rb[k] = 8'($urandom);
        resp_run("glitch");

        // Reset while receiving byte 9
        tx_run(16'($urandom), 1'b0);
        @(negedge clk);
        for (int k = 0; k < 9; k++) send_byte(8'($urandom), 1'b1);
        rx = 1'b0;
        repeat (CPB + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrx_busy", 128'(busy), 128'd0);
        chk("rstrx_response", response, 128'd0);
        chk("rstrx_tx_out", 128'(tx_out), 128'd1);
        chk("rstrx_resp_valid", 128'(resp_valid), 128'd0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        resp_model = '0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a transmitted data bit truncates the frame
        @(negedge clk);
        start     = 1'b1;
        challenge = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("rsttx_line_low", 128'(tx_out), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rsttx_tx_out", 128'(tx_out), 128'd1);
        chk("rsttx_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rsttx_idle_line", 128'(tx_out), 128'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
